fifo_axis_reader: RTL and testbench

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

---
 rtl/fifo_axis_reader.sv | 139 +++++++++++++
 tb/tb_fifo_axis_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
// Drains an upstream FWFT-less FIFO (data one cycle after rd_en) into an AXI-Stream master with tlast framing.
// Optional FIFO_AXIS_READER_STATS_EN adds a 32-bit completed-frame counter output.
module fifo_axis_reader #(
    parameter int WIDTH     = 32,
    parameter int FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             rd_en,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy
`ifdef FIFO_AXIS_READER_STATS_EN
    ,
    output logic [31:0]      frame_count
`endif
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [15:0]      idx_q, idx_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             last0_q, last0_d, last1_q, last1_d;

    logic             pop;
    logic             rd_last;
    logic [1:0]       pending;
    logic [1:0]       occ_pop;

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = data0_q;
    assign m_axis_tlast  = last0_q & m_axis_tvalid;
    assign busy          = (state_q != IDLE) || inflight_q || (occ_q != 2'd0);

    assign pop     = m_axis_tvalid && m_axis_tready;
    assign occ_pop = occ_q - {1'b0, pop};
    // Words that will sit in the buffer once the in-flight read lands and the head pops.
    assign pending = occ_pop + {1'b0, inflight_q};
    assign rd_last = (idx_q == LAST_IDX);
    assign rd_en   = ((state_q == ACTIVE) || (state_q == FINISH)) && !fifo_empty
                     && (pending < 2'd2);

    always_comb begin
        idx_d           = idx_q;
        inflight_d      = rd_en;
        inflight_last_d = rd_en && rd_last;
        occ_d           = occ_pop;
        data0_d         = data0_q;
        data1_d         = data1_q;
        last0_d         = last0_q;
        last1_d         = last1_q;
        state_d         = state_q;

        if (rd_en) begin
            idx_d = rd_last ? 16'd0 : idx_q + 16'd1;
        end

        if (pop) begin
            data0_d = data1_q;
            last0_d = last1_q;
        end

        if (inflight_q) begin
            if (occ_pop == 2'd0) begin
                data0_d = data_out;
                last0_d = inflight_last_q;
            end else begin
                data1_d = data_out;
                last1_d = inflight_last_q;
            end
            occ_d = occ_pop + 2'd1;
        end

        // Frame-boundary decisions use the index after this cycle's read.
        case (state_q)
            IDLE: begin
                if (enable) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!enable) state_d = (idx_d == 16'd0) ? IDLE : FINISH;
            end
            FINISH: begin
                if (enable)                 state_d = ACTIVE;
                else if (idx_d == 16'd0)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= '0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
        end
    end

`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0] frame_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_q <= '0;
        end else if (pop && m_axis_tlast) begin
            frame_count_q <= frame_count_q + 32'd1;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed/random bench for fifo_axis_reader: upstream FIFO model, in-order scoreboard, tlast every FL beats.
// Checks frame_count when FIFO_AXIS_READER_STATS_EN is defined.
module tb_fifo_axis_reader;

    localparam int W  = 32;
    localparam int FL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] data_out = '0;
    logic         rd_en;
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready = 1'b1;
    logic         tlast;
    logic         busy;
`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0]  frame_count;
`endif

    always #5 clk = ~clk;

    fifo_axis_reader #(.WIDTH(W), .FRAME_LEN(FL)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .data_out      (data_out),
        .rd_en         (rd_en),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy)
`ifdef FIFO_AXIS_READER_STATS_EN
        ,
        .frame_count   (frame_count)
`endif
    );

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] fifo[$];
    logic [W-1:0] exp_q[$];
    int           reads = 0;
    int           beats = 0;
    int           beat_idx = 0;
    bit           pat_en = 0;
    int           pat_cnt = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    bit           rd_seen = 0;
    bit           obs_tvalid = 0;
    bit           obs_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        logic [W-1:0] w;
        chk("rd_while_empty", 32'(rd_en & fifo_empty), 32'd0);
        if (prev_stall) begin
            chk("stall_tvalid", 32'(tvalid), 32'd1);
            chk("stall_tdata", tdata, prev_data);
            chk("stall_tlast", 32'(tlast), 32'(prev_last));
        end
        obs_tvalid = tvalid;
        obs_rd     = rd_en;
        rd_seen    = rd_en;
        if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("beat_data", tdata, w);
                chk("beat_tlast", 32'(tlast), 32'(beat_idx % FL == FL - 1));
            end
            beat_idx++;
            beats++;
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
    endtask

    task automatic update();
        if (rd_seen) begin
            if (fifo.size() > 0) begin
                data_out = fifo.pop_front();
                exp_q.push_back(data_out);
            end
            reads++;
        end
        fifo_empty = (fifo.size() == 0);
        if (pat_en) begin
            pat_cnt++;
            tready = (pat_cnt % 4 == 0) || (pat_cnt % 4 == 3);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic run_beats(input int n, input int budget, input string tag);
        int start = beats;
        int c = 0;
        while ((beats - start) < n && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 32'(beats - start), 32'(n));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},  32'(rd_en),  32'd0);
        chk({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        chk({tag, "_tlast"},  32'(tlast),  32'd0);
        chk({tag, "_tdata"},  tdata,       32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
    endtask

    initial begin
        int r0;
        int b0;
        int c;

        // Reset with a preloaded FIFO and enable already high.
        #2 rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) push_word(32'(i));
        tick();
        tick();
        chk_reset_outputs("rst0");
        rst = 1'b0;
        tick();
        chk("rd_after_release", 32'(obs_rd), 32'd0);

        // Back-to-back frames 0..11 with no gaps once streaming.
        c = 0;
        while (beats < 12 && c < 60) begin
            b0 = beats;
            tick();
            c++;
            if (b0 >= 1 && b0 < 12) chk("no_gap", 32'(obs_tvalid), 32'd1);
        end
        chk("p1_beats", 32'(beats), 32'd12);
        chk("p1_exp_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure pattern 1,0,0,1 with random data.
        pat_cnt = 0;
        pat_en  = 1;
        tready  = 1'b1;
        for (int i = 0; i < 24; i++) push_word($urandom);
        run_beats(24, 200, "p2_beats");
        pat_en = 0;
        tready = 1'b1;
        chk("p2_exp_empty", 32'(exp_q.size()), 32'd0);

        // Drop enable mid-frame: the frame still completes, then reading stops.
        for (int i = 0; i < 10; i++) push_word(32'h300 + 32'(i));
        r0 = reads;
        b0 = beats;
        c  = 0;
        while ((reads - r0) < 2 && c < 20) begin
            tick();
            c++;
        end
        enable = 1'b0;
        repeat (20) tick();
        chk("p3_reads", 32'(reads - r0), 32'd4);
        chk("p3_beats", 32'(beats - b0), 32'd4);
        chk("p3_busy", 32'(busy), 32'd0);
        chk("p3_fifo_left", 32'(fifo.size()), 32'd6);
        fifo.delete();
        fifo_empty = 1'b1;

        // Single word presented for one cycle; tvalid two cycles later.
        enable = 1'b1;
        repeat (3) tick();
        b0 = beats;
        push_word(32'hA5);
        tick();
        chk("p4_rd_c0", 32'(obs_rd), 32'd1);
        chk("p4_tvalid_c0", 32'(obs_tvalid), 32'd0);
        tick();
        chk("p4_tvalid_c1", 32'(obs_tvalid), 32'd0);
        tick();
        chk("p4_tvalid_c2", 32'(obs_tvalid), 32'd1);
        repeat (3) tick();
        chk("p4_beats", 32'(beats - b0), 32'd1);

        // Reset with data buffered and a read in flight.
        tready = 1'b0;
        for (int i = 0; i < 14; i++) push_word(32'h500 + 32'(i));
        r0 = reads;
        c  = 0;
        while ((reads - r0) < 2 && c < 20) begin
            tick();
            c++;
        end
        chk("p5_pre_reads", 32'(reads - r0), 32'd2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst1");
        exp_q.delete();
        beat_idx   = 0;
        prev_stall = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rd_after_release2", 32'(obs_rd), 32'd0);
        tready = 1'b1;
        run_beats(12, 80, "p5_beats");
        chk("p5_exp_empty", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_AXIS_READER_STATS_EN
        chk("frame_count", frame_count, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
